img_raster_reader: RTL
======================

Name: img_raster_reader

Overview:
- Read-side master for an imgbuf read port; drains a finished image (e.g. the gauss_filter_5x5 destination buffer) in raster order.
- Issues (px,py) reads and buffers the returned pixels in a credit-controlled FIFO.
- Emits a valid/ready pixel stream with line/frame markers to a downstream sink (file dumper, display or DMA).
- Replaces hand-written bench readout loops and tolerates sink backpressure.

Parameters:
- IMG_W, 256, pixels per line (1..511)
- IMG_H, 256, lines per frame (1..511)
- FIFO_DEPTH, 4, return-data FIFO entries (power of 2, >= 2); also the max reads in flight

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel is accepted downstream
- err  out  1  sticky; set by a stray or overflowing rd_vl; cleared only by rst
- rd_en  out  1  imgbuf read enable
- rd_px  out  10  read x, 0..IMG_W-1 (upper bits zero)
- rd_py  out  10  read y, 0..IMG_H-1
- rd_dt  in  8  read data
- rd_vl  in  1  read data valid; fixed latency >= 1 after rd_en, order preserved
- out_vld  out  1  stream valid
- out_rdy  in  1  stream ready
- out_dt  out  8  pixel
- out_sol  out  1  first pixel of a line (x==0)
- out_eol  out  1  last pixel of a line (x==IMG_W-1)
- out_sof  out  1  first pixel of the frame
- out_eof  out  1  last pixel of the frame

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters, credits and FIFO cleared. Reset mid-frame aborts the frame with no done pulse. Returns still in flight after reset release are counted as stray and set err.
- FSM states:
  - IDLE: start -> RUN; clear issue x/y, output x/y and credit count; busy=1 from the next cycle.
  - RUN: rd_en=1 in every cycle where credits < FIFO_DEPTH. Credits = reads issued but not yet popped at the output.
    - Addresses advance x first; at x==IMG_W-1, x wraps to 0 and y increments.
    - After issuing (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: rd_en=0. When the beat with out_eof is accepted (out_vld & out_rdy) -> IDLE; done=1 for one cycle; busy falls in the same cycle.
- start outside IDLE: ignored.
- rd_en, rd_px and rd_py are registered; px/py are valid only while rd_en=1, otherwise 0.
- Credit accounting:
  - Increment on rd_en; decrement on an output handshake; simultaneous increment and decrement leave the count unchanged.
  - This guarantees the FIFO never overflows.
- rd_vl handling:
  - rd_vl while the FIFO is full, or while in IDLE: data dropped, err=1.
  - Otherwise, rd_vl pushes rd_dt into the FIFO in the same cycle.
- Output side:
  - out_vld = FIFO not empty; out_dt = FIFO head, first-word-fall-through.
  - Push and pop may occur in the same cycle, including when the FIFO is full and popping.
  - out_* must be held stable while out_vld & !out_rdy.
- Markers come from output-side x/y counters advanced on each handshake, not from the address path:
  - sol: x==0; eol: x==IMG_W-1
  - sof: x==0 & y==0; eof: x==IMG_W-1 & y==IMG_H-1
  - IMG_W=1: sol and eol are set together on every beat.
- Throughput: 1 pixel/clk when out_rdy is held high and FIFO_DEPTH > read latency.
- Total handshakes per frame: exactly IMG_W*IMG_H.

Decomposition:
- Package img_pkg: IMG_COORD_W=10, IMG_PIX_W=8, the state enum {IDLE,RUN,DRAIN}, and a pixel-with-markers struct.
- One sub-module: img_fifo_fwft (DEPTH and WIDTH parameters; push, pop, full, empty, count).
- The top level holds the FSM, address counters, credit counter and output counters.

Test Plan:
- IMG_W=4, IMG_H=2, imgbuf latency 1, out_rdy=1, pixel value = y*16+x -> rd_en continuous for 8 cycles; out_dt sequence 00,01,02,03,10,11,12,13; sol on beats 0 and 4; eol on beats 3 and 7; sof on beat 0 only; eof on beat 7 only; done 1 cycle after beat 7 is accepted; err=0.
- Same setup with out_rdy toggled 1010 and then held 0 for 20 cycles -> at most FIFO_DEPTH=4 reads outstanding; out_dt held stable while stalled; no err; same 8-value sequence.
- IMG_W=IMG_H=256 full frame, out_rdy=1 -> exactly 65536 handshakes; the last beat has eof with x=255, y=255; addresses never exceed 255.
- start pulsed again mid-RUN -> ignored; the frame completes normally with a single done pulse.
- rst asserted mid-RUN after 5 beats -> all outputs 0 immediately with no done; a new start produces a full, correct frame.
- rd_vl forced high for one cycle in IDLE -> err=1 and stays high until rst; out_vld stays 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and widths for the image raster reader.
package img_pkg;

  localparam int IMG_COORD_W = 10;
  localparam int IMG_PIX_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } img_state_t;

  // One output beat: pixel plus its line/frame markers.
  typedef struct packed {
    logic [IMG_PIX_W-1:0] dt;
    logic                 sol;
    logic                 eol;
    logic                 sof;
    logic                 eof;
  } img_beat_t;

endpackage

// File: rtl/img_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on dout whenever
// empty is low. A push into a full FIFO is accepted only if a pop happens
// in the same cycle.
module img_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/img_raster_reader.sv
// Raster-order read master for an imgbuf read port. Issues (px,py) reads
// under credit control, buffers returns in a FWFT FIFO and streams pixels
// out with line/frame markers derived from output-side counters.
module img_raster_reader
  import img_pkg::*;
#(
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   rd_en,
  output logic [IMG_COORD_W-1:0] rd_px,
  output logic [IMG_COORD_W-1:0] rd_py,
  input  logic [IMG_PIX_W-1:0]   rd_dt,
  input  logic                   rd_vl,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [IMG_PIX_W-1:0]   out_dt,
  output logic                   out_sol,
  output logic                   out_eol,
  output logic                   out_sof,
  output logic                   out_eof
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IMG_COORD_W-1:0] X_LAST = IMG_COORD_W'(IMG_W - 1);
  localparam logic [IMG_COORD_W-1:0] Y_LAST = IMG_COORD_W'(IMG_H - 1);

  img_state_t             state;
  img_state_t             state_nx;
  logic [IMG_COORD_W-1:0] ix, iy;
  logic [IMG_COORD_W-1:0] ox, oy;
  logic [CW-1:0]          credits;
  logic                   frame_init;
  logic                   frame_end;
  logic                   issue;
  logic                   pop;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [IMG_PIX_W-1:0]   fifo_dout;
  logic                   err_q;
  logic                   done_q;
  img_beat_t              beat;

  // A popped slot frees its credit in the same cycle, so reads keep flowing
  // at one per clock once the pipeline is primed.
  assign pop  = !fifo_empty && out_rdy;
  assign push = rd_vl && (state != IDLE) && (!fifo_full || pop);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    frame_init = 1'b0;
    frame_end  = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = RUN;
          frame_init = 1'b1;
        end
      end
      RUN: begin
        issue = (credits < CW'(FIFO_DEPTH)) || pop;
        if (issue && (ix == X_LAST) && (iy == Y_LAST)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && beat.eof) begin
          state_nx  = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read-address generation; address outputs are zero whenever rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en <= 1'b0;
      rd_px <= '0;
      rd_py <= '0;
      ix    <= '0;
      iy    <= '0;
    end else begin
      rd_en <= issue;
      rd_px <= issue ? ix : '0;
      rd_py <= issue ? iy : '0;
      if (frame_init) begin
        ix <= '0;
        iy <= '0;
      end else if (issue) begin
        if (ix == X_LAST) begin
          ix <= '0;
          iy <= iy + IMG_COORD_W'(1);
        end else begin
          ix <= ix + IMG_COORD_W'(1);
        end
      end
    end
  end

  // Credits: reads issued and not yet handed downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= '0;
    end else if (frame_init) begin
      credits <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Output-side raster position, advanced on every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox <= '0;
      oy <= '0;
    end else if (frame_init) begin
      ox <= '0;
      oy <= '0;
    end else if (pop) begin
      if (ox == X_LAST) begin
        ox <= '0;
        oy <= oy + IMG_COORD_W'(1);
      end else begin
        ox <= ox + IMG_COORD_W'(1);
      end
    end
  end

  // Sticky error for returns nobody asked for, plus the end-of-frame pulse.
  // The occupancy count (not the full flag) flags overflow so a full FIFO
  // that is popping in the same cycle still accepts the return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (rd_vl && ((state == IDLE) || ((fifo_count == CW'(FIFO_DEPTH)) && !pop)))
        err_q <= 1'b1;
      done_q <= frame_end;
    end
  end

  img_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IMG_PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rd_dt),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output beat; everything reads as zero while no pixel is presented.
  always_comb begin
    beat = '0;
    if (!fifo_empty) begin
      beat.dt  = fifo_dout;
      beat.sol = (ox == '0);
      beat.eol = (ox == X_LAST);
      beat.sof = (ox == '0) && (oy == '0);
      beat.eof = (ox == X_LAST) && (oy == Y_LAST);
    end
  end

  assign out_vld = !fifo_empty;
  assign out_dt  = beat.dt;
  assign out_sol = beat.sol;
  assign out_eol = beat.eol;
  assign out_sof = beat.sof;
  assign out_eof = beat.eof;
  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule
